// File: rtl/hazard_scoreboard.sv
// ID-stage hazard tracker: in-flight destination tags, operand forwarding and load-use stall; outputs are combinational, issue lands 1 cycle later.
// HAZARD_FWD_EN selects forwarding; when undefined any in-flight match interlocks (stall is the only backpressure, hold freezes all state).
module hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic                      issue_is_load,
    input  logic [ADDR_W-1:0]         issue_waddr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
    input  logic [DEPTH*DATA_W-1:0]   stage_result,
    output logic                      stall,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [15:0]               stall_cycles
);

    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0]          ent_wen;
    logic [DEPTH-1:0]          ent_load;
    logic [ADDR_W-1:0]         ent_waddr [DEPTH];
    logic [DEPTH-1:0]          stage_ready;
    logic [NUM_SRC-1:0]        port_match;
    logic [NUM_SRC-1:0]        port_ready;
    logic [NUM_SRC*DATA_W-1:0] fwd_data;
    logic                      take;

    always_comb begin
        stage_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_ready[i] = !ent_load[i] || (i >= LOAD_READY);
        end
    end

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        port_match = '0;
        port_ready = '0;
        fwd_data   = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (src_used[p] && (src_addr[p*ADDR_W +: ADDR_W] != '0) &&
                    ent_valid[i] && ent_wen[i] &&
                    (ent_waddr[i] == src_addr[p*ADDR_W +: ADDR_W])) begin
                    port_match[p]                 = 1'b1;
                    port_ready[p]                 = stage_ready[i];
                    fwd_data[p*DATA_W +: DATA_W]  = stage_result[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef HAZARD_FWD_EN
    always_comb begin
        stall    = (|(port_match & ~port_ready)) && !flush;
        fwd_hit  = port_match & port_ready;
        src_data = rf_rdata;
        for (int p = 0; p < NUM_SRC; p++) begin
            if (port_match[p] && port_ready[p]) begin
                src_data[p*DATA_W +: DATA_W] = fwd_data[p*DATA_W +: DATA_W];
            end
        end
    end
`else
    logic unused_fwd;

    always_comb begin
        stall      = (|port_match) && !flush;
        fwd_hit    = '0;
        src_data   = rf_rdata;
        unused_fwd = ^{fwd_data, port_ready};
    end
`endif

    assign take = issue_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid    <= '0;
            ent_wen      <= '0;
            ent_load     <= '0;
            stall_cycles <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_waddr[i] <= '0;
            end
        end else if (!hold) begin
            ent_valid[0] <= take;
            ent_wen[0]   <= take && issue_wen && (issue_waddr != '0);
            ent_load[0]  <= take && issue_is_load;
            ent_waddr[0] <= issue_waddr;
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_wen[i]   <= ent_wen[i-1];
                ent_load[i]  <= ent_load[i-1];
                ent_waddr[i] <= ent_waddr[i-1];
            end
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule
